// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream valid/ready channel feeding the instruction loader.
//   in_data  : stream byte (master -> slave)
//   in_valid : in_data valid this cycle (master -> slave)
//   in_ready : loader can accept a byte; transfer on in_valid & in_ready (slave -> master)
interface imem_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input  in_ready);
   modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction loader. Receives a count byte N followed by
// 3*N data bytes (MSB first per 24-bit word), writes the words sequentially into
// instruction memory starting at address 0, and holds the core in reset until
// the load completes.
//
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing checksum
// byte (XOR of all data bytes); a mismatch parks the loader in ERR.
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   s        : byte stream (imem_loader_if.slave: in_data, in_valid, in_ready)
//   wa       : instruction-memory write address
//   wd       : instruction-memory write data
//   we       : instruction-memory write strobe, one cycle per word
//   cpu_rst  : reset to the core, 1 until the load completes
//   done     : load complete
//   err      : checksum failure (constant 0 without LOADER_CHECKSUM_EN)
module imem_loader #(
   parameter int unsigned AW = 8
) (
   input  logic              clk,
   input  logic              rst,
   imem_loader_if.slave      s,
   output logic [AW-1:0]     wa,
   output logic [23:0]       wd,
   output logic              we,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);

   // Remaining-word counter needs one extra bit to hold 2^AW for a count of 0.
   localparam int unsigned REM_W = AW + 1;

   typedef enum logic [2:0] {
      ST_CNT,
      ST_B0,
      ST_B1,
      ST_B2,
`ifdef LOADER_CHECKSUM_EN
      ST_CHK,
`endif
      ST_RUN,
      ST_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [7:0]       b0_q, b0_d;
   logic [7:0]       b1_q, b1_d;
   logic [AW-1:0]    wa_q, wa_d;
   logic [23:0]      wd_q, wd_d;
   logic             we_q, we_d;
   logic             in_ready_q, in_ready_d;
   logic             cpu_rst_q, cpu_rst_d;
   logic             done_q, done_d;
   logic             accept;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]       csum_q, csum_d;
   logic             err_q, err_d;
`endif

   assign accept = s.in_valid & in_ready_q;

   // Next-state and registered-output computation.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      b0_d    = b0_q;
      b1_d    = b1_q;
      wa_d    = wa_q;
      wd_d    = wd_q;
      we_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif

      if (accept) begin
         case (state_q)
            ST_CNT: begin
               rem_d   = (s.in_data == 8'd0) ? (REM_W'(1) << AW) : REM_W'(s.in_data);
               addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = 8'd0;
`endif
               state_d = ST_B0;
            end
            ST_B0: begin
               b0_d    = s.in_data;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ s.in_data;
`endif
               state_d = ST_B1;
            end
            ST_B1: begin
               b1_d    = s.in_data;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ s.in_data;
`endif
               state_d = ST_B2;
            end
            ST_B2: begin
               we_d    = 1'b1;
               wa_d    = addr_q;
               wd_d    = {b0_q, b1_q, s.in_data};
               addr_d  = addr_q + AW'(1);
               rem_d   = rem_q - REM_W'(1);
`ifdef LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ s.in_data;
               state_d = (rem_q == REM_W'(1)) ? ST_CHK : ST_B0;
`else
               state_d = (rem_q == REM_W'(1)) ? ST_RUN : ST_B0;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
               state_d = (s.in_data == csum_q) ? ST_RUN : ST_ERR;
            end
`endif
            default: ;
         endcase
      end

      // Status outputs are decoded from the upcoming state so they change
      // in the same cycle the state does.
      in_ready_d = (state_d != ST_RUN) && (state_d != ST_ERR);
      cpu_rst_d  = (state_d != ST_RUN);
      done_d     = (state_d == ST_RUN);
`ifdef LOADER_CHECKSUM_EN
      err_d      = (state_d == ST_ERR);
`endif
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_CNT;
         addr_q     <= '0;
         rem_q      <= '0;
         b0_q       <= 8'd0;
         b1_q       <= 8'd0;
         wa_q       <= '0;
         wd_q       <= 24'd0;
         we_q       <= 1'b0;
         in_ready_q <= 1'b0;
         cpu_rst_q  <= 1'b1;
         done_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= 8'd0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         b0_q       <= b0_d;
         b1_q       <= b1_d;
         wa_q       <= wa_d;
         wd_q       <= wd_d;
         we_q       <= we_d;
         in_ready_q <= in_ready_d;
         cpu_rst_q  <= cpu_rst_d;
         done_q     <= done_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
         err_q      <= err_d;
`endif
      end
   end

   assign s.in_ready = in_ready_q;
   assign wa         = wa_q;
   assign wd         = wd_q;
   assign we         = we_q;
   assign cpu_rst    = cpu_rst_q;
   assign done       = done_q;
`ifdef LOADER_CHECKSUM_EN
   assign err        = err_q;
`else
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Stimulus pushes expected
// {wa, wd} writes into a queue; a monitor pops and compares on every we pulse.
// Honors LOADER_CHECKSUM_EN to append checksum bytes and run the checksum cases.
module tb_imem_loader;
   localparam int unsigned AW = 8;

   logic          clk;
   logic          rst;
   logic [AW-1:0] wa;
   logic [23:0]   wd;
   logic          we;
   logic          cpu_rst;
   logic          done;
   logic          err;

   imem_loader_if bus ();

   imem_loader #(.AW(AW)) dut (
      .clk     (clk),
      .rst     (rst),
      .s       (bus),
      .wa      (wa),
      .wd      (wd),
      .we      (we),
      .cpu_rst (cpu_rst),
      .done    (done),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write actual=%h expected=none", {wa, wd});
            end else begin
               e = exp_q.pop_front();
               chk("write", {wa, wd}, e);
            end
         end
      end
   end

   // Present one byte and hold it until accepted; gap idle cycles afterwards.
   task automatic send(input logic [7:0] b, input int gap);
      int n;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.in_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=in_ready_low expected=accept byte %h", b);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (gap > 0) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
   endtask

   // Drop valid and check the loader released the core right after the last byte.
   task automatic expect_done(input string tag);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   // Stream N=2: 12 34 56 AB CD EF; checksum 12^34^56^AB^CD^EF = F9.
   task automatic load_two(input int gap, input string tag);
      logic [7:0] s2 [6];
      s2 = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
      exp_q.push_back({8'h00, 24'h123456});
      exp_q.push_back({8'h01, 24'hABCDEF});
      send(8'h02, gap);
      send(s2[0], gap);
      chk({tag, "_cpu_rst_loading"}, 32'(cpu_rst), 32'd1);
      for (int i = 1; i < 6; i++) begin
`ifdef LOADER_CHECKSUM_EN
         send(s2[i], gap);
`else
         send(s2[i], (i == 5) ? 0 : gap);
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      send(8'hF9, 0);
`endif
      expect_done(tag);
      repeat (2) @(negedge clk);
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] z;
      logic [7:0] cs;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_wa", 32'(wa), 32'd0);
      chk("rst_wd", 32'(wd), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_release", 32'(bus.in_ready), 32'd1);

      // Back-to-back load.
      load_two(0, "b2b");

      // Same stream with two idle cycles between bytes.
      do_reset(2);
      load_two(2, "stall");

      // N=0: full 256-word load, word i = {i, i^5A, ~i}.
      do_reset(2);
      cs = 8'h00;
      send(8'h00, 0);
      for (int i = 0; i < 256; i++) begin
         x = 8'(i);
         y = x ^ 8'h5A;
         z = ~x;
         exp_q.push_back({x, x, y, z});
         cs = cs ^ x ^ y ^ z;
         send(x, 0);
         send(y, 0);
         send(z, 0);
      end
`ifdef LOADER_CHECKSUM_EN
      send(cs, 0);
`endif
      expect_done("n0");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = 8'hFF;
         @(negedge clk);
         chk("n0_extra_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("n0_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("n0_done_held", 32'(done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
      // Correct checksum: 01^02^03 = 00.
      do_reset(2);
      exp_q.push_back({8'h00, 24'h010203});
      send(8'h01, 0);
      send(8'h01, 0);
      send(8'h02, 0);
      send(8'h03, 0);
      chk("chk_cpu_rst_before_sum", 32'(cpu_rst), 32'd1);
      send(8'h00, 0);
      expect_done("chk_good");

      // Bad checksum.
      do_reset(2);
      exp_q.push_back({8'h00, 24'h010203});
      send(8'h01, 0);
      send(8'h01, 0);
      send(8'h02, 0);
      send(8'h03, 0);
      send(8'h55, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("chk_bad_err", 32'(err), 32'd1);
      chk("chk_bad_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("chk_bad_in_ready", 32'(bus.in_ready), 32'd0);
      chk("chk_bad_done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      chk("chk_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

      // Reset after 4 data bytes: only word 0 written, then a fresh load.
      do_reset(2);
      exp_q.push_back({8'h00, 24'h123456});
      send(8'h02, 0);
      send(8'h12, 0);
      send(8'h34, 0);
      send(8'h56, 0);
      send(8'hAB, 0);
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("midrst_we", 32'(we), 32'd0);
      chk("midrst_wa", 32'(wa), 32'd0);
      chk("midrst_wd", 32'(wd), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
      rst = 1'b0;
      exp_q.push_back({8'h00, 24'h0A0B0C});
      send(8'h01, 0);
      send(8'h0A, 0);
      send(8'h0B, 0);
      send(8'h0C, 0);
`ifdef LOADER_CHECKSUM_EN
      send(8'h0D, 0);
`endif
      expect_done("restart");
      repeat (3) @(negedge clk);
      chk("restart_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
